// File: rtl/rheed_pkg.sv
// Shared types and default geometry for the RHEED crop stream.
package rheed_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NORM_PASS     = 2'd0,
      NORM_INVERT   = 2'd1,
      NORM_HALVE    = 2'd2,
      NORM_PASS_ALT = 2'd3
   } norm_mode_e;

   localparam int DEF_PIXEL_BIT_WIDTH = 8;
   localparam int DEF_BEAT_PIXELS     = 32;
   localparam int DEF_IN_ROWS         = 100;
   localparam int DEF_IN_COLS         = 160;
   localparam int DEF_OUT_ROWS        = 48;
   localparam int DEF_OUT_COLS        = 48;

endpackage

// File: rtl/rheed_pix_norm.sv
// Combinational pixel normaliser: pass, invert, or halve; zero latency, no flow control.
module rheed_pix_norm
   import rheed_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH
) (
   input  logic [1:0]                 mode,
   input  logic [PIXEL_BIT_WIDTH-1:0] pix,
   output logic [PIXEL_BIT_WIDTH-1:0] norm_pix
);

   always_comb begin
      norm_pix = pix;
      case (norm_mode_e'(mode))
         NORM_INVERT:   norm_pix = ~pix;
         NORM_HALVE:    norm_pix = pix >> 1;
         NORM_PASS,
         NORM_PASS_ALT: norm_pix = pix;
         default:       norm_pix = pix;
      endcase
   end

endmodule

// File: rtl/rheed_crop_stream.sv
// Crops a window out of a beat-wide raster frame and streams it one normalised pixel per handshake.
// Window pixels appear the cycle after their beat is accepted; input stalls only while a window beat drains.
module rheed_crop_stream
   import rheed_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
   parameter int BEAT_PIXELS     = DEF_BEAT_PIXELS,
   parameter int IN_ROWS         = DEF_IN_ROWS,
   parameter int IN_COLS         = DEF_IN_COLS,
   parameter int OUT_ROWS        = DEF_OUT_ROWS,
   parameter int OUT_COLS        = DEF_OUT_COLS
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   ap_start,
   output logic                                   ap_ready,
   output logic                                   ap_idle,
   output logic                                   ap_done,
   input  logic                                   continuous,
   input  logic [1:0]                             norm_mode,
   input  logic [$clog2(IN_COLS)-1:0]             crop_x0,
   input  logic [$clog2(IN_ROWS)-1:0]             crop_y0,
   input  logic                                   s_axis_tvalid,
   output logic                                   s_axis_tready,
   input  logic [BEAT_PIXELS*PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
   output logic                                   m_axis_tvalid,
   input  logic                                   m_axis_tready,
   output logic [PIXEL_BIT_WIDTH-1:0]             m_axis_tdata,
   output logic                                   m_axis_tlast,
   output logic                                   crop_err,
   output logic [15:0]                            frame_count
);

   localparam int XW        = $clog2(IN_COLS);
   localparam int YW        = $clog2(IN_ROWS);
   localparam int BEAT_COLS = IN_COLS / BEAT_PIXELS;
   localparam int BCW       = (BEAT_COLS > 1) ? $clog2(BEAT_COLS) : 1;
   localparam int KW        = (BEAT_PIXELS > 1) ? $clog2(BEAT_PIXELS) : 1;
   localparam int CW        = $clog2(IN_COLS + BEAT_PIXELS) + 1;
   localparam int RW        = $clog2(IN_ROWS + OUT_ROWS) + 1;
   localparam int OUT_PIX   = OUT_ROWS * OUT_COLS;
   localparam int OW        = $clog2(OUT_PIX + 1);
   localparam int X_MAX     = IN_COLS - OUT_COLS;
   localparam int Y_MAX     = IN_ROWS - OUT_ROWS;
   localparam int BW        = BEAT_PIXELS * PIXEL_BIT_WIDTH;

   state_e                     state;
   logic [BCW-1:0]             col_cnt;
   logic [YW-1:0]              row_cnt;
   logic [XW-1:0]              x0_q;
   logic [YW-1:0]              y0_q;
   norm_mode_e                 mode_q;
   logic                       buf_full;
   logic [BW-1:0]              buf_dat;
   logic [KW-1:0]              buf_k;
   logic [KW-1:0]              buf_last;
   logic [OW-1:0]              out_cnt;
   logic                       tlast_seen;

   logic [XW-1:0]              x0_eff;
   logic [YW-1:0]              y0_eff;
   logic                       clamp;
   logic [CW-1:0]              col_lo;
   logic [CW-1:0]              col_hi;
   logic [CW-1:0]              win_lo;
   logic [CW-1:0]              win_hi;
   logic                       row_hit;
   logic                       col_hit;
   logic                       in_win;
   logic [KW-1:0]              first_k;
   logic [KW-1:0]              last_k;
   logic [PIXEL_BIT_WIDTH-1:0] pix_cur;
   logic [PIXEL_BIT_WIDTH-1:0] norm_pix;
   logic                       m_hs;
   logic                       s_hs;
   logic                       buf_drain;
   logic                       last_beat;
   logic                       beats_done;
   logic                       tlast_done;
   logic                       frame_done;

   always_comb begin
      x0_eff = crop_x0;
      y0_eff = crop_y0;
      clamp  = 1'b0;
      if (crop_x0 > XW'(X_MAX)) begin
         x0_eff = XW'(X_MAX);
         clamp  = 1'b1;
      end
      if (crop_y0 > YW'(Y_MAX)) begin
         y0_eff = YW'(Y_MAX);
         clamp  = 1'b1;
      end
   end

   // Column span of the current beat against the latched window, in pixel units.
   always_comb begin
      col_lo  = CW'(col_cnt) * CW'(BEAT_PIXELS);
      col_hi  = col_lo + CW'(BEAT_PIXELS - 1);
      win_lo  = CW'(x0_q);
      win_hi  = CW'(x0_q) + CW'(OUT_COLS - 1);
      row_hit = (RW'(row_cnt) >= RW'(y0_q)) && (RW'(row_cnt) < RW'(y0_q) + RW'(OUT_ROWS));
      col_hit = (col_lo <= win_hi) && (col_hi >= win_lo);
      in_win  = row_hit && col_hit;
      first_k = (win_lo > col_lo) ? KW'(win_lo - col_lo) : '0;
      last_k  = (win_hi < col_hi) ? KW'(win_hi - col_lo) : KW'(BEAT_PIXELS - 1);
   end

   assign pix_cur = buf_dat[buf_k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];

   rheed_pix_norm #(
      .PIXEL_BIT_WIDTH (PIXEL_BIT_WIDTH)
   ) u_norm (
      .mode     (mode_q),
      .pix      (pix_cur),
      .norm_pix (norm_pix)
   );

   assign ap_idle       = (state == ST_IDLE);
   assign ap_ready      = (state == ST_IDLE);
   assign m_axis_tvalid = buf_full;
   assign m_axis_tdata  = buf_full ? norm_pix : '0;
   assign m_axis_tlast  = buf_full && (out_cnt == OW'(OUT_PIX - 1));

   assign m_hs          = buf_full && m_axis_tready;
   assign buf_drain     = m_hs && (buf_k == buf_last);
   // A beat may enter on the same edge the buffer's final window pixel leaves.
   assign s_axis_tready = !reset && (state == ST_RUN) && (!buf_full || buf_drain);
   assign s_hs          = s_axis_tvalid && s_axis_tready;
   assign last_beat     = (col_cnt == BCW'(BEAT_COLS - 1)) && (row_cnt == YW'(IN_ROWS - 1));
   assign beats_done    = (state == ST_FLUSH) || (s_hs && last_beat);
   assign tlast_done    = tlast_seen || (m_hs && m_axis_tlast);
   assign frame_done    = (state != ST_IDLE) && beats_done && tlast_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         col_cnt     <= '0;
         row_cnt     <= '0;
         x0_q        <= '0;
         y0_q        <= '0;
         mode_q      <= NORM_PASS;
         buf_full    <= 1'b0;
         buf_dat     <= '0;
         buf_k       <= '0;
         buf_last    <= '0;
         out_cnt     <= '0;
         tlast_seen  <= 1'b0;
         ap_done     <= 1'b0;
         frame_count <= '0;
         crop_err    <= 1'b0;
      end else begin
         ap_done <= 1'b0;

         if (m_hs) begin
            out_cnt <= m_axis_tlast ? '0 : out_cnt + OW'(1);
            if (m_axis_tlast) tlast_seen <= 1'b1;
            if (buf_k == buf_last) buf_full <= 1'b0;
            else                   buf_k    <= buf_k + KW'(1);
         end

         if (s_hs) begin
            if (in_win) begin
               buf_full <= 1'b1;
               buf_dat  <= s_axis_tdata;
               buf_k    <= first_k;
               buf_last <= last_k;
            end
            if (col_cnt == BCW'(BEAT_COLS - 1)) begin
               col_cnt <= '0;
               row_cnt <= last_beat ? '0 : row_cnt + YW'(1);
            end else begin
               col_cnt <= col_cnt + BCW'(1);
            end
         end

         case (state)
            ST_IDLE: begin
               if (ap_start) begin
                  state      <= ST_RUN;
                  x0_q       <= x0_eff;
                  y0_q       <= y0_eff;
                  mode_q     <= norm_mode_e'(norm_mode);
                  crop_err   <= clamp;
                  col_cnt    <= '0;
                  row_cnt    <= '0;
                  out_cnt    <= '0;
                  tlast_seen <= 1'b0;
               end
            end
            ST_RUN, ST_FLUSH: begin
               if (frame_done) begin
                  ap_done     <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  tlast_seen  <= 1'b0;
                  // Restart re-latches the window but keeps crop_err sticky until the next ap_start.
                  if (continuous) begin
                     state    <= ST_RUN;
                     x0_q     <= x0_eff;
                     y0_q     <= y0_eff;
                     mode_q   <= norm_mode_e'(norm_mode);
                     crop_err <= crop_err | clamp;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if ((state == ST_RUN) && s_hs && last_beat) begin
                  state <= ST_FLUSH;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rheed_crop_stream.sv
// Scoreboarded bench for rheed_crop_stream: directed frames, expected pixels queued per accepted beat.
module tb_rheed_crop_stream;

   localparam int BEATS   = 500;
   localparam int OUT_PIX = 2304;

   logic         clk = 1'b0;
   logic         reset;
   logic         ap_start, ap_ready, ap_idle, ap_done, continuous;
   logic [1:0]   norm_mode;
   logic [7:0]   crop_x0;
   logic [6:0]   crop_y0;
   logic         s_axis_tvalid, s_axis_tready;
   logic [255:0] s_axis_tdata;
   logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [7:0]   m_axis_tdata;
   logic         crop_err;
   logic [15:0]  frame_count;

   always #5 clk = ~clk;

   rheed_crop_stream #(
      .PIXEL_BIT_WIDTH (8),
      .BEAT_PIXELS     (32),
      .IN_ROWS         (100),
      .IN_COLS         (160),
      .OUT_ROWS        (48),
      .OUT_COLS        (48)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ap_start      (ap_start),
      .ap_ready      (ap_ready),
      .ap_idle       (ap_idle),
      .ap_done       (ap_done),
      .continuous    (continuous),
      .norm_mode     (norm_mode),
      .crop_x0       (crop_x0),
      .crop_y0       (crop_y0),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .crop_err      (crop_err),
      .frame_count   (frame_count)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         n_cmp = 0;
   int         n_err = 0;
   int         pop_cnt = 0;
   int         done_cnt = 0;
   int         pix_idx = 0;
   int         ex0, ey0;
   int         ntab;
   int         clear_at = -1;
   int         poke_at = -1;
   int         pat_tab[3];
   logic [7:0] raw_tab[3];
   logic [7:0] exp_tab[3];
   logic [1:0] mode_tab[3];
   logic       rnd_rdy = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic summary_and_finish();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   endtask

   task automatic abort(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
      summary_and_finish();
   endtask

   // Raw input pixel and the pixel the window should emit for it, per frame table entry.
   function automatic logic [7:0] pix_raw(input int f, input int r, input int x);
      case (pat_tab[f])
         0:       return 8'(x);
         1:       return raw_tab[f];
         default: return 8'(r + x);
      endcase
   endfunction

   function automatic logic [7:0] pix_exp(input int f, input int r, input int x);
      case (pat_tab[f])
         0:       return 8'(x);
         1:       return exp_tab[f];
         default: return 8'(r + x);
      endcase
   endfunction

   function automatic logic [255:0] beat_data(input int f, input int r, input int c);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < 32; k++) d[k*8 +: 8] = pix_raw(f, r, c*32 + k);
      return d;
   endfunction

   task automatic push_beat(input int f, input int r, input int c);
      exp_t ne;
      for (int k = 0; k < 32; k++) begin
         if (r >= ey0 && r < ey0 + 48 && (c*32 + k) >= ex0 && (c*32 + k) < ex0 + 48) begin
            ne.d    = pix_exp(f, r, c*32 + k);
            ne.last = (pix_idx == OUT_PIX - 1);
            q.push_back(ne);
            pix_idx = (pix_idx == OUT_PIX - 1) ? 0 : pix_idx + 1;
         end
      end
   endtask

   // Ready pattern for the output stream, changed just after each rising edge.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", 32'(m_axis_tdata), 32'(prev_d));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pixel: got %0h expected none", m_axis_tdata);
            end else begin
               e = q.pop_front();
               check("pix_data", 32'(m_axis_tdata), 32'(e.d));
               check("pix_last", 32'(m_axis_tlast), 32'(e.last));
            end
            pop_cnt++;
         end
         if (ap_done) done_cnt++;
         prev_stall <= m_axis_tvalid && !m_axis_tready;
         prev_d     <= m_axis_tdata;
      end
   end

   task automatic start_frame(input int x, input int y, input int m);
      crop_x0   = 8'(x);
      crop_y0   = 7'(y);
      norm_mode = 2'(m);
      ap_start  = 1'b1;
      @(posedge clk);
      #1;
      ap_start  = 1'b0;
   endtask

   task automatic drive(input int nbeats, output int idle_hits);
      idle_hits = 0;
      for (int b = 0; b < nbeats; b++) begin
         int f, bb, r, c, w;
         f  = b / BEATS;
         bb = b % BEATS;
         r  = bb / 5;
         c  = bb % 5;
         if (bb == BEATS - 1 && f + 1 < ntab) norm_mode = mode_tab[f+1];
         if (b == clear_at) continuous = 1'b0;
         if (b == poke_at) begin
            crop_x0 = '0; crop_y0 = '0; norm_mode = 2'd1; ap_start = 1'b1;
         end
         if (b == poke_at + 1) ap_start = 1'b0;
         s_axis_tdata  = beat_data(f, r, c);
         s_axis_tvalid = 1'b1;
         w = 0;
         @(negedge clk);
         while (!s_axis_tready) begin
            if (ap_idle) idle_hits++;
            w++;
            if (w > 2000) abort("beat_accept_timeout");
            @(negedge clk);
         end
         push_beat(f, r, c);
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int w;
      w = 0;
      while (done_cnt < target) begin
         @(negedge clk);
         w++;
         if (w > 6000) abort("done_timeout");
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic end_checks(input int base_done, input int ndone, input int base_pop,
                             input int fc, input int err);
      check("done_pulses", 32'(done_cnt - base_done), 32'(ndone));
      check("frame_count", 32'(frame_count), 32'(fc));
      check("crop_err", 32'(crop_err), 32'(err));
      check("pixel_total", 32'(pop_cnt - base_pop), 32'(ndone * OUT_PIX));
      check("queue_empty", 32'(q.size()), 32'd0);
      check("idle_after", 32'(ap_idle), 32'd1);
   endtask

   task automatic reset_checks();
      check("rst_ap_idle", 32'(ap_idle), 32'd1);
      check("rst_ap_ready", 32'(ap_ready), 32'd1);
      check("rst_ap_done", 32'(ap_done), 32'd0);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_crop_err", 32'(crop_err), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
   endtask

   task automatic set_tab(input int i, input int pat, input logic [7:0] raw,
                          input logic [7:0] expv, input logic [1:0] mode);
      pat_tab[i]  = pat;
      raw_tab[i]  = raw;
      exp_tab[i]  = expv;
      mode_tab[i] = mode;
   endtask

   initial begin
      int bd, bp, ih;
      reset = 1'b1; ap_start = 1'b0; continuous = 1'b0; norm_mode = '0;
      crop_x0 = '0; crop_y0 = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      reset_checks();

      // Full-origin window, column-valued pixels.
      ntab = 1; set_tab(0, 0, 8'h00, 8'h00, 2'd0); ex0 = 0; ey0 = 0;
      bd = done_cnt; bp = pop_cnt;
      start_frame(0, 0, 0);
      drive(BEATS, ih);
      wait_done(bd + 1);
      end_checks(bd, 1, bp, 1, 0);

      // Offset window under random output backpressure; mid-frame input changes must be ignored.
      ex0 = 20; ey0 = 10; rnd_rdy = 1'b1; poke_at = 100;
      bd = done_cnt; bp = pop_cnt;
      start_frame(20, 10, 0);
      drive(BEATS, ih);
      poke_at = -1; rnd_rdy = 1'b0;
      wait_done(bd + 1);
      end_checks(bd, 1, bp, 2, 0);

      // Out-of-range origin clamps to 112/52.
      set_tab(0, 2, 8'h00, 8'h00, 2'd0); ex0 = 112; ey0 = 52;
      bd = done_cnt; bp = pop_cnt;
      start_frame(150, 90, 0);
      check("clamp_err_set", 32'(crop_err), 32'd1);
      drive(BEATS, ih);
      wait_done(bd + 1);
      end_checks(bd, 1, bp, 3, 1);

      // Three back-to-back frames, one normalisation mode each.
      ntab = 3; ex0 = 0; ey0 = 0;
      set_tab(0, 1, 8'h10, 8'hEF, 2'd1);
      set_tab(1, 1, 8'hFF, 8'h7F, 2'd2);
      set_tab(2, 1, 8'h5A, 8'h5A, 2'd3);
      continuous = 1'b1; clear_at = 1100;
      bd = done_cnt; bp = pop_cnt;
      start_frame(0, 0, 1);
      check("clamp_err_clear", 32'(crop_err), 32'd0);
      drive(3 * BEATS, ih);
      clear_at = -1;
      wait_done(bd + 3);
      check("cont_idle_hits", 32'(ih), 32'd0);
      end_checks(bd, 3, bp, 6, 0);

      // Reset partway through a clamped frame, then a clean frame.
      ntab = 1; set_tab(0, 2, 8'h00, 8'h00, 2'd0); ex0 = 112; ey0 = 3;
      start_frame(200, 3, 0);
      drive(200, ih);
      check("pre_reset_err", 32'(crop_err), 32'd1);
      reset = 1'b1;
      s_axis_tvalid = 1'b0;
      q.delete();
      pix_idx = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      reset_checks();
      ex0 = 7; ey0 = 40;
      bd = done_cnt; bp = pop_cnt;
      start_frame(7, 40, 0);
      drive(BEATS, ih);
      wait_done(bd + 1);
      end_checks(bd, 1, bp, 1, 0);

      summary_and_finish();
   end

endmodule
